// File: rtl/tspi_pkg.sv
// Shared TSPI types and idle-level constants for controller and target port logic.
package tspi_pkg;

    localparam logic TspiIdleClk = 1'b1;
    localparam logic TspiIdleCs  = 1'b1;
    localparam logic TspiIdleSdi = 1'b0;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tspi_tgt_state_e;

endpackage

// File: rtl/tspi_sync_edge.sv
// Multi-flop synchroniser with a preset value and single-cycle rise/fall event pulses.
module tspi_sync_edge #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic [Stages-1:0] sync_q;
    logic              edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {Stages{ResetVal}};
            edge_q <= ResetVal;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d};
            edge_q <= sync_q[Stages-1];
        end
    end

    assign rise_c = sync_q[Stages-1] & ~edge_q;
    assign fall_c = ~sync_q[Stages-1] & edge_q;

endmodule

// File: rtl/tspi_target_port.sv
// TSPI target port: oversamples the controller pads, deserialises MOSI words onto a
// valid/ready stream and serialises response words onto MISO.
module tspi_target_port
    import tspi_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tspi_clk_i,
    input  logic                 cs_ni,
    input  logic                 sdi_i,
    output logic                 sdo_o,
    output logic                 sdo_oe_o,
    output logic [DataWidth-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    input  logic [DataWidth-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 frame_busy_o,
    output logic                 abort_o,
    output logic                 rx_ovf_o,
    output logic                 tx_udf_o,
    input  logic                 clr_err_i
);

    localparam int unsigned        CntW    = $clog2(DataWidth);
    localparam logic [CntW-1:0]    CntLast = CntW'(DataWidth - 1);

    logic clk_rise_c, clk_fall_c, cs_rise_c, cs_fall_c;

    tspi_sync_edge #(.Stages(SyncStages), .ResetVal(TspiIdleClk)) u_sync_clk (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (tspi_clk_i),
        .rise_c (clk_rise_c),
        .fall_c (clk_fall_c)
    );

    tspi_sync_edge #(.Stages(SyncStages), .ResetVal(TspiIdleCs)) u_sync_cs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d      (cs_ni),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    tspi_tgt_state_e        state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [DataWidth-2:0]   rx_shift_q, rx_shift_d;
    logic [DataWidth-1:0]   tx_word_q, tx_word_d;
    logic [DataWidth-1:0]   rx_data_q, rx_data_d;
    logic [DataWidth-1:0]   rx_word;
    logic [SyncStages-1:0]  sdi_q;
    logic                   sdo_q, sdo_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   abort_q, abort_d;
    logic                   rx_ovf_q, rx_ovf_d;
    logic                   tx_udf_q, tx_udf_d;
    logic                   clr_q;
    logic                   clr_rise;
    logic                   load_slot;
    logic                   ovf_set, udf_set;
    logic                   sdi_s;

    // sdi is delayed by the synchroniser depth so it stays aligned with the clock edge events
    assign sdi_s    = sdi_q[SyncStages-1];
    assign clr_rise = clr_err_i & ~clr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_shift_d = rx_shift_q;
        tx_word_d  = tx_word_q;
        sdo_d      = sdo_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready_i;
        tx_ready_d = 1'b0;
        abort_d    = 1'b0;
        load_slot  = 1'b0;
        ovf_set    = 1'b0;
        udf_set    = 1'b0;
        rx_word    = {rx_shift_q, sdi_s};

        case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    load_slot = 1'b1;
                end
            end
            SHIFT: begin
                // CS release has priority over a coincident clock rise
                if (cs_rise_c) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sdo_d   = 1'b1;
                    abort_d = (cnt_q != '0);
                end else begin
                    if (clk_rise_c) begin
                        rx_shift_d = rx_word[DataWidth-2:0];
                        if (cnt_q == CntLast) begin
                            cnt_d     = '0;
                            load_slot = 1'b1;
                            if (!rx_valid_q || rx_ready_i) begin
                                rx_data_d  = rx_word;
                                rx_valid_d = 1'b1;
                            end else begin
                                ovf_set = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                    if (clk_fall_c) begin
                        sdo_d = tx_word_q[CntLast - cnt_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // New slot: its MSB goes out immediately so it is valid at the first rise
        if (load_slot) begin
            tx_ready_d = tx_valid_i;
            udf_set    = ~tx_valid_i;
            tx_word_d  = tx_valid_i ? tx_data_i : '0;
            sdo_d      = tx_valid_i & tx_data_i[DataWidth-1];
        end

        rx_ovf_d = ovf_set | (rx_ovf_q & ~clr_rise);
        tx_udf_d = udf_set | (tx_udf_q & ~clr_rise);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_word_q  <= '0;
            rx_data_q  <= '0;
            sdi_q      <= {SyncStages{TspiIdleSdi}};
            sdo_q      <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            abort_q    <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_udf_q   <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_word_q  <= tx_word_d;
            rx_data_q  <= rx_data_d;
            sdi_q      <= {sdi_q[SyncStages-2:0], sdi_i};
            sdo_q      <= sdo_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            abort_q    <= abort_d;
            rx_ovf_q   <= rx_ovf_d;
            tx_udf_q   <= tx_udf_d;
            clr_q      <= clr_err_i;
        end
    end

    assign sdo_o        = sdo_q;
    assign sdo_oe_o     = (state_q == SHIFT);
    assign frame_busy_o = (state_q == SHIFT);
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign tx_ready_o   = tx_ready_q;
    assign abort_o      = abort_q;
    assign rx_ovf_o     = rx_ovf_q;
    assign tx_udf_o     = tx_udf_q;

endmodule

// File: tb/tb_tspi_target_port.sv
// Directed and randomised frames against the TSPI target port, checked against a word-level model.
module tb_tspi_target_port;

    localparam int unsigned DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          tspi_clk_i = 1'b1;
    logic          cs_ni = 1'b1;
    logic          sdi_i = 1'b0;
    logic          sdo_o, sdo_oe_o;
    logic [DW-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready_i = 1'b1;
    logic [DW-1:0] tx_data_i = '0;
    logic          tx_valid_i = 1'b0;
    logic          tx_ready_o, frame_busy_o, abort_o, rx_ovf_o, tx_udf_o;
    logic          clr_err_i = 1'b0;

    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;
    int            abort_cnt = 0;
    int            txr_cnt = 0;
    int            hold_viol = 0;
    logic [DW-1:0] hs_data = '0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    tspi_target_port #(.DataWidth(DW), .SyncStages(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .tspi_clk_i   (tspi_clk_i),
        .cs_ni        (cs_ni),
        .sdi_i        (sdi_i),
        .sdo_o        (sdo_o),
        .sdo_oe_o     (sdo_oe_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .rx_ready_i   (rx_ready_i),
        .tx_data_i    (tx_data_i),
        .tx_valid_i   (tx_valid_i),
        .tx_ready_o   (tx_ready_o),
        .frame_busy_o (frame_busy_o),
        .abort_o      (abort_o),
        .rx_ovf_o     (rx_ovf_o),
        .tx_udf_o     (tx_udf_o),
        .clr_err_i    (clr_err_i)
    );

    always #5 clk_i = ~clk_i;

    // Observe handshakes and pulses away from the active edge
    always @(negedge clk_i) begin
        if (rx_valid_o && rx_ready_i) begin
            hs_cnt  <= hs_cnt + 1;
            hs_data <= rx_data_o;
        end
        if (prev_hold && rx_valid_o && (rx_data_o !== prev_data)) hold_viol <= hold_viol + 1;
        if (abort_o) abort_cnt <= abort_cnt + 1;
        if (tx_ready_o) txr_cnt <= txr_cnt + 1;
        prev_hold <= rx_valid_o && !rx_ready_i;
        prev_data <= rx_data_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Controller model: data changes on falling edges, target samples on rising edges
    task automatic frame(input int nbits, input logic [63:0] mosi, input bit release_cs,
                         output logic [63:0] miso);
        miso  = '0;
        cs_ni = 1'b0;
        tick(6);
        for (int i = nbits - 1; i >= 0; i--) begin
            tspi_clk_i = 1'b0;
            sdi_i      = mosi[i];
            tick(4);
            miso[i]    = sdo_o;
            tspi_clk_i = 1'b1;
            tick(4);
        end
        if (release_cs) begin
            cs_ni = 1'b1;
            tick(8);
        end
    endtask

    task automatic pulse_clr();
        clr_err_i = 1'b1;
        tick(1);
        clr_err_i = 1'b0;
        tick(2);
    endtask

    function automatic logic [DW-1:0] exp_miso(input logic valid, input logic [DW-1:0] data);
        return valid ? data : '0;
    endfunction

    logic [63:0]   miso;
    logic [DW-1:0] w1, w2, txw;
    logic          v;
    int            hs0, ab0, tr0;

    initial begin
        // Reset state
        tick(3);
        check("reset_flags", 64'({sdo_o, sdo_oe_o, frame_busy_o, rx_valid_o, tx_ready_o,
                                  abort_o, rx_ovf_o, tx_udf_o}), 64'(8'b1000_0000));
        check("reset_rx_data", 64'(rx_data_o), 64'(0));
        rst_ni = 1'b1;
        tick(4);

        // Basic word exchange
        tx_data_i = 32'h1234_5678; tx_valid_i = 1'b1; rx_ready_i = 1'b1;
        hs0 = hs_cnt; tr0 = txr_cnt;
        frame(32, 64'h0000_0000_A5A5_F00D, 1'b1, miso);
        check("t1_miso", 64'(miso[31:0]), 64'h1234_5678);
        check("t1_rx_pulses", 64'(hs_cnt - hs0), 64'(1));
        check("t1_rx_data", 64'(hs_data), 64'hA5A5_F00D);
        check("t1_tx_ready_pulses", 64'(txr_cnt - tr0), 64'(2));
        check("t1_idle_pins", 64'({sdo_o, sdo_oe_o, frame_busy_o, rx_ovf_o, tx_udf_o}), 64'(5'b10000));

        // Back-to-back words with consumer stalled
        w1 = $urandom; w2 = $urandom; txw = $urandom;
        tx_data_i = txw; rx_ready_i = 1'b0; hs0 = hs_cnt;
        frame(64, {w1, w2}, 1'b1, miso);
        check("t2_valid_held", 64'(rx_valid_o), 64'(1));
        check("t2_data_held", 64'(rx_data_o), 64'(w1));
        check("t2_ovf", 64'(rx_ovf_o), 64'(1));
        check("t2_miso", miso, {txw, txw});
        rx_ready_i = 1'b1;
        tick(2);
        check("t2_drain_count", 64'(hs_cnt - hs0), 64'(1));
        check("t2_drain_data", 64'(hs_data), 64'(w1));
        check("t2_valid_clear", 64'(rx_valid_o), 64'(0));
        pulse_clr();
        check("t2_ovf_clear", 64'(rx_ovf_o), 64'(0));

        // Underflow: no tx word offered
        tx_valid_i = 1'b0; tx_data_i = $urandom; w1 = $urandom;
        hs0 = hs_cnt; tr0 = txr_cnt;
        frame(32, 64'(w1), 1'b1, miso);
        check("t3_miso_zero", 64'(miso[31:0]), 64'(0));
        check("t3_udf", 64'(tx_udf_o), 64'(1));
        check("t3_no_tx_ready", 64'(txr_cnt - tr0), 64'(0));
        check("t3_rx_data", 64'(hs_data), 64'(w1));
        pulse_clr();
        check("t3_udf_clear", 64'(tx_udf_o), 64'(0));

        // CS released after 13 bits, then a clean frame
        tx_valid_i = 1'b1; txw = $urandom; tx_data_i = txw;
        hs0 = hs_cnt; ab0 = abort_cnt;
        frame(13, 64'($urandom), 1'b1, miso);
        check("t4_abort_once", 64'(abort_cnt - ab0), 64'(1));
        check("t4_no_rx", 64'(hs_cnt - hs0), 64'(0));
        check("t4_idle", 64'({frame_busy_o, sdo_oe_o, sdo_o}), 64'(3'b001));
        w1 = $urandom;
        frame(32, 64'(w1), 1'b1, miso);
        check("t4_next_rx", 64'(hs_data), 64'(w1));
        check("t4_next_count", 64'(hs_cnt - hs0), 64'(1));
        check("t4_next_miso", 64'(miso[31:0]), 64'(txw));
        check("t4_no_extra_abort", 64'(abort_cnt - ab0), 64'(1));

        // Clock activity while deselected
        for (int i = 0; i < 10; i++) begin
            tspi_clk_i = 1'b0; sdi_i = 1'($urandom); tick(4);
            tspi_clk_i = 1'b1; tick(4);
        end
        check("t5_deselected", 64'({frame_busy_o, sdo_oe_o, sdo_o}), 64'(3'b001));
        w1 = $urandom; hs0 = hs_cnt;
        frame(32, 64'(w1), 1'b1, miso);
        check("t5_rx_after_toggle", 64'(hs_data), 64'(w1));
        check("t5_miso_after_toggle", 64'(miso[31:0]), 64'(txw));

        // Randomised frames against the word-level model
        for (int k = 0; k < 4; k++) begin
            v = 1'($urandom_range(0, 1));
            txw = $urandom; w1 = $urandom;
            tx_valid_i = v; tx_data_i = txw; hs0 = hs_cnt;
            frame(32, 64'(w1), 1'b1, miso);
            check("rnd_rx", 64'(hs_data), 64'(w1));
            check("rnd_miso", 64'(miso[31:0]), 64'(exp_miso(v, txw)));
            check("rnd_udf", 64'(tx_udf_o), 64'(!v));
            pulse_clr();
        end

        // Reset in the middle of a word
        tx_valid_i = 1'b0; ab0 = abort_cnt;
        frame(10, 64'($urandom), 1'b0, miso);
        check("t6_busy_mid", 64'(frame_busy_o), 64'(1));
        check("t6_udf_mid", 64'(tx_udf_o), 64'(1));
        rst_ni = 1'b0;
        #1;
        check("t6_async_reset", 64'({sdo_o, sdo_oe_o, frame_busy_o, rx_valid_o, tx_ready_o,
                                     abort_o, rx_ovf_o, tx_udf_o}), 64'(8'b1000_0000));
        tspi_clk_i = 1'b1; cs_ni = 1'b1;
        tick(3);
        rst_ni = 1'b1;
        tick(4);
        check("t6_no_abort", 64'(abort_cnt - ab0), 64'(0));
        tx_valid_i = 1'b1; txw = $urandom; tx_data_i = txw; w1 = $urandom; hs0 = hs_cnt;
        frame(32, 64'(w1), 1'b1, miso);
        check("t6_rx_after_reset", 64'(hs_data), 64'(w1));
        check("t6_rx_count", 64'(hs_cnt - hs0), 64'(1));
        check("t6_miso_after_reset", 64'(miso[31:0]), 64'(txw));

        check("rx_hold_stable", 64'(hold_viol), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
